clink_uart_cmd_ctrl: RTL and testbench
======================================

# clink_uart_cmd_ctrl

Configuration-command controller for the Camera Link serial (UART) channel. Software pushes camera command bytes from the AXI register side into an internal FIFO. The block serialises them on `tx_serial` (8N1). After each command terminator (0x0D) it waits for the camera's reply byte on `rx_serial`, with a timeout. It sits between the AXI register decoder and the camera's serial pins, alongside the Camera Link pixel receiver, and paces configuration traffic so software never overruns the camera.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 125_000_000, frequency of `s_axi_aclk`.
- `BAUD_RATE`, 9600, UART bit rate. `BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE`, integer division (truncate); `BAUD_DIV` ≥ 4 is required.
- `FIFO_DEPTH`, 16, command FIFO depth in bytes; power of two.
- `TIMEOUT_CYCLES`, 12_500_000, clock cycles to wait for a reply after 0x0D.

Ports:
- `s_axi_aclk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  push `wr_data` into the FIFO (AXI_WRITE_FIFO strobe).
- `wr_data`  in  8  command byte.
- `wr_ready`  out  1  high when FIFO not full.
- `flush`  in  1  one-cycle pulse (AXI_FLUSH_FIFO strobe); empties the FIFO and clears `timeout_err`.
- `tx_serial`  out  1  UART TX to the camera; idle high.
- `rx_serial`  in  1  UART RX from the camera; asynchronous input.
- `rsp_valid`  out  1  one-cycle pulse, received byte valid.
- `rsp_data`  out  8  last received byte.
- `framing_err`  out  1  one-cycle pulse, stop bit sampled low.
- `busy`  out  1  TX FSM not in IDLE.
- `timeout_err`  out  1  sticky reply-timeout flag.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

## Operation
- **FIFO**
  - Write when `wr_valid && wr_ready`. If full, `wr_valid` is ignored and the byte is dropped.
  - `flush` empties the FIFO in one cycle. `flush` together with `wr_valid` in the same cycle: flush wins and the byte is dropped.
  - Simultaneous push and pop in one cycle is legal; `fifo_level` is unchanged.
- **TX FSM** (IDLE, LOAD, START, DATA, STOP, WAIT_RSP):
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD pops one byte into the shift register, then → START.
  - START drives 0 for `BAUD_DIV` cycles, then → DATA.
  - DATA sends 8 bits LSB first, `BAUD_DIV` cycles each, then → STOP.
  - STOP drives 1 for `BAUD_DIV` cycles. After STOP:
    - byte == 0x0D → WAIT_RSP;
    - otherwise FIFO non-empty → LOAD;
    - otherwise → IDLE.
  - WAIT_RSP → LOAD/IDLE (by FIFO state) on `rsp_valid`. If the wait counter reaches `TIMEOUT_CYCLES`, set `timeout_err` and leave the same way.
  - `flush` never aborts a byte in flight. It only empties the queue.
- **RX path**
  - `rx_serial` passes through a 2-FF synchroniser. A falling edge starts a byte.
  - At `BAUD_DIV/2` the line is rechecked. If high, it is a false start and RX returns to idle.
  - 8 data bits are sampled at bit centres, then the stop bit.
  - Stop bit high: `rsp_data` is updated and `rsp_valid` pulses. Stop bit low: `framing_err` pulses, `rsp_data` is unchanged, no `rsp_valid`.
  - RX runs independently of TX. Replies arriving outside WAIT_RSP still pulse `rsp_valid`.

## Timing
- Reset values:
  - `tx_serial`=1, `wr_ready`=1;
  - `rsp_valid`, `framing_err`, `busy`, `timeout_err`=0;
  - `rsp_data`=0x00, `fifo_level`=0.
- Reset mid-byte: `tx_serial` returns to 1 immediately, and the FIFO and all FSMs clear.
- Write into an empty FIFO at edge N → `tx_serial` falls at edge N+2 (LOAD at N+1).
- Byte duration is `10*BAUD_DIV` cycles. Back-to-back bytes take `10*BAUD_DIV+1` cycles each (one LOAD cycle, line held high).
- `rsp_valid` asserts 1 cycle after the stop-bit centre sample; the receive path has 2 cycles of synchroniser latency.
- The timeout counter starts on the first cycle of WAIT_RSP. `timeout_err` asserts on the cycle after the count reaches `TIMEOUT_CYCLES`.
- `wr_ready` is updated on the same edge as the FIFO count.

## Configuration
- **Macro `CLINK_UART_RSP_WAIT_EN`.**
  - Defined: WAIT_RSP state and timeout counter are present, as above.
  - Undefined:
    - STOP never enters WAIT_RSP; 0x0D is an ordinary byte;
    - `timeout_err` is tied 0;
    - no timeout counter is synthesised.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1_000_000, `BAUD_RATE`=100_000 (`BAUD_DIV`=10), `FIFO_DEPTH`=4, `TIMEOUT_CYCLES`=200.
- **Single byte.** Write 0xCA into empty FIFO at edge N → `tx_serial` low from N+2 for 10 cycles, then bits 0,1,0,1,0,0,1,1 (10 cycles each), then high; `busy` falls after 100 cycles of frame.
- **Full FIFO.** Write 5 bytes back-to-back while idle. Bytes 1–5 are accepted, because the first is popped at LOAD. The 6th write while `fifo_level`=4 → `wr_ready`=0 and the byte is dropped; transmitted sequence matches the accepted order.
- **Reply handling.** Send 0x0D then 0x41.
  - Camera model replies 0x06 → `rsp_valid` pulse with `rsp_data`=0x06, then 0x41 is sent.
  - No reply → `timeout_err`=1 about 200 cycles after the STOP phase ends, then 0x41 is sent.
  - `flush` → `timeout_err`=0.
- **Flush mid-byte.** Queue 3 bytes; pulse `flush` during byte 1's DATA phase together with `wr_valid` → byte 1 completes, nothing further is sent, `fifo_level`=0.
- **RX errors.**
  - 3-cycle low glitch on `rx_serial` → no `rsp_valid`.
  - Frame with stop bit 0 → `framing_err` pulse, `rsp_data` unchanged.
- **Reset mid-frame.** Assert `reset` during START → `tx_serial`=1 and `fifo_level`=0 asynchronously; after release a new write transmits normally.

Source files
------------

// File: rtl/clink_uart_cmd_ctrl.sv
// Camera Link serial command controller: byte FIFO -> 8N1 UART TX, UART RX reply capture.
// Optional reply-wait/timeout after 0x0D is enabled by defining CLINK_UART_RSP_WAIT_EN.
module clink_uart_cmd_ctrl #(
  parameter int CLK_FREQ_HZ    = 125_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 12_500_000
) (
  input  logic                          s_axi_aclk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic                          flush,
  output logic                          tx_serial,
  input  logic                          rx_serial,
  output logic                          rsp_valid,
  output logic [7:0]                    rsp_data,
  output logic                          framing_err,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_WAIT_RSP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // ---------------- command FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, fifo_empty;

  assign wr_ready   = (count_q != FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign fifo_level = count_q;
  assign push       = wr_valid && wr_ready && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge s_axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------- TX FSM ----------------
  tx_state_e     state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign busy      = (state_q != S_IDLE);
  assign tx_serial = tx_q;

  logic rsp_valid_q;

`ifdef CLINK_UART_RSP_WAIT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pop        = 1'b0;
`ifdef CLINK_UART_RSP_WAIT_EN
    wait_cnt_d = '0;
    timeout_d  = timeout_q && !flush;
`endif
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_LOAD;
      // A flush landing on the way into LOAD can leave the queue empty.
      S_LOAD: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          pop        = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = S_DATA;
        end else baud_cnt_d = baud_cnt_q + 1'b1;
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else baud_cnt_d = baud_cnt_q + 1'b1;
      end
      S_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
`ifdef CLINK_UART_RSP_WAIT_EN
          if (tx_byte_q == 8'h0D) state_d = S_WAIT_RSP;
          else state_d = fifo_empty ? S_IDLE : S_LOAD;
`else
          state_d = fifo_empty ? S_IDLE : S_LOAD;
`endif
        end else baud_cnt_d = baud_cnt_q + 1'b1;
      end
`ifdef CLINK_UART_RSP_WAIT_EN
      S_WAIT_RSP: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (rsp_valid_q) begin
          state_d = fifo_empty ? S_IDLE : S_LOAD;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = fifo_empty ? S_IDLE : S_LOAD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = tx_byte_d[bit_cnt_d];
  end

  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_byte_q  <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- RX path ----------------
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_valid_d, framing_err_q, framing_err_d;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign framing_err = framing_err_q;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    framing_err_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      // Half-bit recheck rejects glitches shorter than half a bit.
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      R_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      R_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_state_d = R_IDLE;
          if (rx_s2_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_shift_q;
          end else begin
            framing_err_d = 1'b1;
          end
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_s3_q       <= 1'b1;
      rx_state_q    <= R_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_s1_q       <= rx_serial;
      rx_s2_q       <= rx_s1_q;
      rx_s3_q       <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

endmodule

// File: tb/tb_clink_uart_cmd_ctrl.sv
// Directed bench for clink_uart_cmd_ctrl (BAUD_DIV=10, FIFO_DEPTH=4, TIMEOUT_CYCLES=200).
module tb_clink_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset, wr_valid, flush, rx_serial;
  logic [7:0] wr_data;
  logic       wr_ready, tx_serial, rsp_valid, framing_err, busy, timeout_err;
  logic [7:0] rsp_data;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  clink_uart_cmd_ctrl #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(200)
  ) dut (
    .s_axi_aclk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .flush(flush), .tx_serial(tx_serial), .rx_serial(rx_serial),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .framing_err(framing_err), .busy(busy),
    .timeout_err(timeout_err), .fifo_level(fifo_level)
  );

  typedef struct { logic [7:0] data; logic [9:0] frame; } tx_vec_t;
  typedef struct { logic [7:0] data; logic stop; int n_valid; int n_ferr; logic [7:0] exp_rsp; } rx_vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, rv_cnt = 0, fe_cnt = 0, last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rv_cnt       <= rv_cnt + 1;
      last_rsp_cyc <= cyc;
    end
    if (framing_err) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop);
    rx_serial = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (10) @(negedge clk);
    end
    rx_serial = stop;
    repeat (10) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  // Camera-side UART receiver: waits (bounded) for a start bit then samples mid-bit.
  task automatic uart_decode(input int limit, output logic seen, output logic [7:0] d,
                             output int start_cyc);
    seen = 1'b0;
    d = '0;
    start_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_serial === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      start_cyc = cyc;
      repeat (4) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (10) @(negedge clk);
        d[b] = tx_serial;
      end
      repeat (10) @(negedge clk);
      check("tx_stop_bit", tx_serial, 1);
    end
  endtask

  tx_vec_t    tx_tab[5];
  rx_vec_t    rx_tab[5];
  logic [7:0] ff_vals[6];
  logic       tx_hist[104];
  logic       busy_hist[104];
  logic [9:0] frame;
  logic       seen;
  logic [7:0] d;
  int         sc, t0, rv0, fe0;

  initial begin
    tx_tab[0] = '{8'hCA, 10'b1_1100_1010_0};
    tx_tab[1] = '{8'h00, 10'b1_0000_0000_0};
    tx_tab[2] = '{8'hFF, 10'b1_1111_1111_0};
    tx_tab[3] = '{8'h55, 10'b1_0101_0101_0};
    tx_tab[4] = '{8'h80, 10'b1_1000_0000_0};
    rx_tab[0] = '{8'h06, 1'b1, 1, 0, 8'h06};
    rx_tab[1] = '{8'h3C, 1'b0, 0, 1, 8'h06};
    rx_tab[2] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    rx_tab[3] = '{8'h00, 1'b0, 0, 1, 8'hA5};
    rx_tab[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    ff_vals   = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_framing_err", framing_err, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_fifo_level", fifo_level, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte frames with exact timing.
    for (int v = 0; v < 5; v++) begin
      push(tx_tab[v].data);
      for (int j = 1; j <= 103; j++) begin
        @(negedge clk);
        tx_hist[j]   = tx_serial;
        busy_hist[j] = busy;
      end
      for (int k = 0; k < 10; k++) frame[k] = tx_hist[7 + 10 * k];
      check($sformatf("tx%0d_latency", v), {tx_hist[1], tx_hist[2]}, 2'b10);
      check($sformatf("tx%0d_frame", v), frame, tx_tab[v].frame);
      check($sformatf("tx%0d_busy", v), {busy_hist[1], busy_hist[101], busy_hist[102]}, 3'b110);
      repeat (2) @(negedge clk);
    end

    // Full FIFO: five accepted, sixth dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr_valid = 1'b1;
          wr_data  = ff_vals[i];
          if (i == 4) check("full_ready_at_3", wr_ready, 1);
          if (i == 5) begin
            check("full_wr_ready", wr_ready, 0);
            check("full_level", fifo_level, 4);
          end
          @(negedge clk);
        end
        wr_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          uart_decode(300, seen, d, sc);
          check($sformatf("full_seen%0d", i), seen, 1);
          check($sformatf("full_byte%0d", i), d, ff_vals[i]);
        end
      end
    join
    uart_decode(150, seen, d, sc);
    check("full_no_sixth", seen, 0);

    // RX glitch then table of received frames.
    rv0 = rv_cnt; fe0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_valid", rv_cnt - rv0, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);
    for (int v = 0; v < 5; v++) begin
      rv0 = rv_cnt; fe0 = fe_cnt;
      rx_send(rx_tab[v].data, rx_tab[v].stop);
      repeat (20) @(negedge clk);
      check($sformatf("rx%0d_valid_cycles", v), rv_cnt - rv0, rx_tab[v].n_valid);
      check($sformatf("rx%0d_ferr_cycles", v), fe_cnt - fe0, rx_tab[v].n_ferr);
      check($sformatf("rx%0d_rsp_data", v), rsp_data, rx_tab[v].exp_rsp);
    end

    // Command terminator handling.
    fork
      begin push(8'h0D); push(8'h41); end
      uart_decode(50, seen, d, sc);
    join
    check("cr_seen", seen, 1);
    check("cr_byte", d, 8'h0D);
`ifdef CLINK_UART_RSP_WAIT_EN
    rv0 = rv_cnt;
    fork
      rx_send(8'h06, 1'b1);
      uart_decode(400, seen, d, sc);
    join
    check("reply_next_seen", seen, 1);
    check("reply_next_byte", d, 8'h41);
    check("reply_valid_count", rv_cnt - rv0, 1);
    check("reply_rsp_data", rsp_data, 8'h06);
    check("reply_order", (sc > last_rsp_cyc) && (sc - last_rsp_cyc < 10), 1);
    check("reply_no_timeout", timeout_err, 0);
    repeat (10) @(negedge clk);

    fork
      begin push(8'h0D); push(8'h41); end
      uart_decode(50, seen, d, sc);
    join
    check("to_cr_byte", d, 8'h0D);
    t0 = cyc;
    uart_decode(400, seen, d, sc);
    check("to_next_seen", seen, 1);
    check("to_next_byte", d, 8'h41);
    check("to_gap", (sc - t0 >= 200) && (sc - t0 <= 220), 1);
    check("to_sticky", timeout_err, 1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("to_flush_clears", timeout_err, 0);
`else
    t0 = cyc;
    uart_decode(50, seen, d, sc);
    check("cr_next_seen", seen, 1);
    check("cr_next_byte", d, 8'h41);
    check("cr_no_wait", sc - t0 < 20, 1);
    check("cr_timeout_tied", timeout_err, 0);
    repeat (10) @(negedge clk);
`endif

    // Flush during DATA of byte 1, together with a write.
    fork
      begin
        push(8'h31); push(8'h32); push(8'h33);
        repeat (40) @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'h99; flush = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; flush = 1'b0;
        check("flush_level", fifo_level, 0);
      end
      uart_decode(50, seen, d, sc);
    join
    check("flush_b1_seen", seen, 1);
    check("flush_b1_byte", d, 8'h31);
    uart_decode(200, seen, d, sc);
    check("flush_nothing_more", seen, 0);
    check("flush_idle", busy, 0);
    check("flush_level_end", fifo_level, 0);

    // Reset while START is on the line.
    push(8'h5A); push(8'h11); push(8'h22);
    repeat (4) @(negedge clk);
    check("rmid_pre_tx", tx_serial, 0);
    check("rmid_pre_level", fifo_level, 2);
    reset = 1'b1;
    #1;
    check("rmid_tx_async", tx_serial, 1);
    check("rmid_level_async", fifo_level, 0);
    check("rmid_busy_async", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rmid_wr_ready", wr_ready, 1);
    fork
      push(8'hC3);
      uart_decode(50, seen, d, sc);
    join
    check("rmid_new_seen", seen, 1);
    check("rmid_new_byte", d, 8'hC3);
    uart_decode(150, seen, d, sc);
    check("rmid_queue_cleared", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
